// File: rtl/accel_sample_bank_pkg.sv
// Shared types and helpers for the accelerometer sample bank.
// Holds the snapshot FSM encoding, default geometry and the LED bar level math.
package accel_pkg;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LED_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } snap_state_e;

  // Saturating |v| scaled onto 0..lw; the most-negative sample clamps to max positive.
  function automatic int bar_level(input logic signed [31:0] v, input int dw, input int lw);
    longint mag;
    longint maxpos;
    longint lvl;
    maxpos = (longint'(1) << (dw - 1)) - 1;
    mag    = longint'(v);
    if (mag < 0) mag = -mag;
    if (mag > maxpos) mag = maxpos;
    lvl = (mag * longint'(lw + 1)) >>> (dw - 1);
    if (lvl > longint'(lw)) lvl = longint'(lw);
    return int'(lvl);
  endfunction

endpackage

// File: rtl/accel_sample_bank_if.sv
// Sample/snapshot/LED signal bundle between the sampling logic and the HPS PIO side.
interface accel_sample_bank_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 16,
  parameter int LED_W  = 10,
  parameter int SEQ_W  = 8
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     mode_avg;
  logic                     snap_req;
  logic                     snap_ack;
  logic [NUM_CH*DATA_W-1:0] snap_data;
  logic [SEQ_W-1:0]         snap_seq;
  logic [SEL_W-1:0]         led_sel;
  logic [LED_W-1:0]         led_bar;

  modport master (
    output in_valid, in_data, mode_avg, snap_req, led_sel,
    input  snap_ack, snap_data, snap_seq, led_bar
  );

  modport slave (
    input  in_valid, in_data, mode_avg, snap_req, led_sel,
    output snap_ack, snap_data, snap_seq, led_bar
  );
endinterface

// File: rtl/accel_avg_ch.sv
// One channel of the sample bank: raw pass-through or 2^AVG_LOG2 block average.
// Block position (last) and mode-change clear come from the shared counter in the top.
module accel_avg_ch #(
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_avg,
  input  logic                     i_valid,
  input  logic                     i_last,
  input  logic signed [DATA_W-1:0] i_sample,
  output logic signed [DATA_W-1:0] o_result,
  output logic                     o_stb
);
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic signed [ACC_W-1:0]  r_acc_p0;
  logic signed [ACC_W-1:0]  w_acc_base;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] r_result_p1;
  logic                     r_vld_p1;

  function automatic logic signed [DATA_W-1:0] avg_div(input logic signed [ACC_W-1:0] s);
    return DATA_W'(s >>> AVG_LOG2);
  endfunction

  // A mode change restarts the block, so the sample in that cycle starts from zero.
  assign w_acc_base = i_clr ? '0 : r_acc_p0;
  assign w_sum      = w_acc_base + ACC_W'(i_sample);

  // p0 -> p1: accumulate, emit average on the last sample of a block
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_p0    <= '0;
      r_result_p1 <= '0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= 1'b0;
      if (!i_avg) begin
        r_acc_p0 <= '0;
        if (i_valid) begin
          r_result_p1 <= i_sample;
          r_vld_p1    <= 1'b1;
        end
      end else if (i_valid) begin
        if (i_last) begin
          r_acc_p0    <= '0;
          r_result_p1 <= avg_div(w_sum);
          r_vld_p1    <= 1'b1;
        end else begin
          r_acc_p0 <= w_sum;
        end
      end else if (i_clr) begin
        r_acc_p0 <= '0;
      end
    end
  end

  assign o_result = r_result_p1;
  assign o_stb    = r_vld_p1;
endmodule

// File: rtl/accel_sample_bank.sv
// Multi-channel accel capture: optional block averaging, coherent req/ack snapshot
// for HPS reads, and a registered magnitude thermometer for the LED PIO.
module accel_sample_bank
  import accel_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AVG_LOG2 = 2,
  parameter int LED_W    = DEF_LED_W,
  parameter int SEQ_W    = 8
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  accel_sample_bank_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic                     r_mode;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_base;
  logic                     w_mode_chg;
  logic                     w_last;
  logic                     w_fire;
  logic signed [DATA_W-1:0] w_res [NUM_CH];
  logic [NUM_CH-1:0]        w_stb;
  logic                     w_res_stb;
  logic [SEQ_W-1:0]         r_seq;

  snap_state_e              r_state;
  snap_state_e              w_state_nxt;
  logic                     w_cap;
  logic                     r_snap_ack;
  logic [NUM_CH*DATA_W-1:0] r_snap_data;
  logic [SEQ_W-1:0]         r_snap_seq;

  logic signed [DATA_W-1:0] w_sel_res;
  logic                     w_sel_ok;
  int                       w_level;
  logic [LED_W-1:0]         w_bar;
  logic [LED_W-1:0]         r_led_bar;

  assign w_mode_chg = bus.mode_avg ^ r_mode;
  assign w_cnt_base = w_mode_chg ? '0 : r_cnt;
  assign w_last     = (w_cnt_base == CNT_LAST);
  assign w_fire     = bus.in_valid & (~bus.mode_avg | w_last);

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      accel_avg_ch #(
        .DATA_W  (DATA_W),
        .AVG_LOG2(AVG_LOG2)
      ) u_ch (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_clr   (w_mode_chg),
        .i_avg   (bus.mode_avg),
        .i_valid (bus.in_valid),
        .i_last  (w_last),
        .i_sample(bus.in_data[k*DATA_W +: DATA_W]),
        .o_result(w_res[k]),
        .o_stb   (w_stb[k])
      );
    end
  endgenerate

  assign w_res_stb = &w_stb;

  // seq advances on the same edge the result registers load, so it is current during res_stb
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_mode <= 1'b0;
      r_cnt  <= '0;
      r_seq  <= '0;
    end else begin
      r_mode <= bus.mode_avg;
      if (!bus.mode_avg)   r_cnt <= '0;
      else if (bus.in_valid) r_cnt <= w_last ? '0 : w_cnt_base + CNT_W'(1);
      else if (w_mode_chg) r_cnt <= '0;
      if (w_fire) r_seq <= r_seq + SEQ_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.snap_req) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!bus.snap_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_res_stb) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: if (!bus.snap_req) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state     <= ST_IDLE;
      r_snap_ack  <= 1'b0;
      r_snap_data <= '0;
      r_snap_seq  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_snap_ack <= (w_state_nxt == ST_HOLD);
      if (w_cap) begin
        for (int k = 0; k < NUM_CH; k++) r_snap_data[k*DATA_W +: DATA_W] <= w_res[k];
        r_snap_seq <= r_seq;
      end
    end
  end

  always_comb begin
    w_sel_res = '0;
    w_sel_ok  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.led_sel == SEL_W'(k)) begin
        w_sel_res = w_res[k];
        w_sel_ok  = 1'b1;
      end
    end
    w_level = w_sel_ok ? bar_level(32'(w_sel_res), DATA_W, LED_W) : 0;
    w_bar   = '0;
    for (int i = 0; i < LED_W; i++) w_bar[i] = (i < w_level);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_led_bar <= '0;
    else             r_led_bar <= w_bar;
  end

  assign bus.snap_ack  = r_snap_ack;
  assign bus.snap_data = r_snap_data;
  assign bus.snap_seq  = r_snap_seq;
  assign bus.led_bar   = r_led_bar;
endmodule

// File: tb/tb_accel_sample_bank.sv
// Directed scoreboard bench for accel_sample_bank (3 ch, 16-bit, 4-sample average).
module tb_accel_sample_bank;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int LED_W  = 10;
  localparam int SEQ_W  = 8;

  typedef struct packed {
    logic [NUM_CH*DATA_W-1:0] data;
    logic [SEQ_W-1:0]         seq;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [SEQ_W-1:0] exp_seq = '0;
  rec_t rq[$];
  rec_t sq[$];
  logic ack_q = 1'b0;

  accel_sample_bank_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .LED_W(LED_W), .SEQ_W(SEQ_W)) bus ();

  accel_sample_bank #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LOG2(2), .LED_W(LED_W), .SEQ_W(SEQ_W)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int c0, input int c1, input int c2);
    bus.in_valid = 1'b1;
    bus.in_data  = {16'(c2), 16'(c1), 16'(c0)};
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_res(input int c0, input int c1, input int c2);
    rec_t e;
    exp_seq++;
    e.data = {16'(c2), 16'(c1), 16'(c0)};
    e.seq  = exp_seq;
    rq.push_back(e);
  endtask

  task automatic expect_snap(input int c0, input int c1, input int c2, input int s);
    rec_t e;
    e.data = {16'(c2), 16'(c1), 16'(c0)};
    e.seq  = 8'(s);
    sq.push_back(e);
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (!rst && dut.w_res_stb) begin
      if (rq.size() == 0) begin
        chk("unexpected_res_stb", 64'd1, 64'd0);
      end else begin
        e = rq.pop_front();
        chk("res_data", {dut.w_res[2], dut.w_res[1], dut.w_res[0]}, e.data);
        chk("res_seq", dut.r_seq, e.seq);
      end
    end
  end

  always @(negedge clk) begin
    rec_t e;
    if (bus.snap_ack && !ack_q) begin
      if (sq.size() == 0) begin
        chk("unexpected_ack", 64'd1, 64'd0);
      end else begin
        e = sq.pop_front();
        chk("snap_data", bus.snap_data, e.data);
        chk("snap_seq", bus.snap_seq, e.seq);
      end
    end
    ack_q <= bus.snap_ack;
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mode_avg = 1'b0;
    bus.snap_req = 1'b0;
    bus.led_sel  = 2'd2;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ack", bus.snap_ack, 0);
    chk("rst_led", bus.led_bar, 0);
    chk("rst_snap_data", bus.snap_data, 0);
    chk("rst_snap_seq", bus.snap_seq, 0);

    // Block average: ch0 4..16 -> 10, ch1 -1..-4 -> -3 (floor)
    bus.mode_avg = 1'b1;
    tick();
    strobe(4, -1, 0);  chk("no_stb1", dut.w_res_stb, 0);
    strobe(8, -2, 0);  chk("no_stb2", dut.w_res_stb, 0);
    strobe(12, -3, 0); chk("no_stb3", dut.w_res_stb, 0);
    expect_res(10, -3, 0);
    strobe(16, -4, 0);

    // Raw mode and LED bar
    bus.mode_avg = 1'b0;
    expect_res(0, 0, 16383);
    strobe(0, 0, 16383);
    tick();
    chk("led_16383", bus.led_bar, 10'h01F);
    expect_res(0, 0, -32768);
    strobe(0, 0, -32768);
    tick();
    chk("led_neg_full", bus.led_bar, 10'h3FF);
    bus.led_sel = 2'd3;
    tick();
    chk("led_sel_oob", bus.led_bar, 10'h000);
    bus.led_sel = 2'd2;
    tick();
    chk("led_sel_back", bus.led_bar, 10'h3FF);

    // Snapshot: res_stb coinciding with req rise is skipped
    expect_res(1, 2, 3);
    strobe(1, 2, 3);
    bus.snap_req = 1'b1;
    tick();
    expect_res(5, 6, 7);
    expect_snap(5, 6, 7, 5);
    strobe(5, 6, 7);
    chk("ack_not_yet", bus.snap_ack, 0);
    tick();
    chk("ack_rise", bus.snap_ack, 1);
    expect_res(9, 9, 9);    strobe(9, 9, 9);
    expect_res(10, 11, 12); strobe(10, 11, 12);
    expect_res(-1, -1, -1); strobe(-1, -1, -1);
    chk("hold_data", bus.snap_data, {16'd7, 16'd6, 16'd5});
    chk("hold_seq", bus.snap_seq, 5);
    chk("hold_ack", bus.snap_ack, 1);
    bus.snap_req = 1'b0;
    for (int i = 0; i < 4 && bus.snap_ack; i++) tick();
    chk("ack_fall", bus.snap_ack, 0);
    chk("done_data", bus.snap_data, {16'd7, 16'd6, 16'd5});
    tick();
    tick();

    // req dropped while waiting: no capture, no ack
    bus.snap_req = 1'b1;
    tick();
    bus.snap_req = 1'b0;
    tick();
    expect_res(2, 2, 2);
    strobe(2, 2, 2);
    tick();
    chk("wait_abort_ack", bus.snap_ack, 0);
    chk("wait_abort_seq", bus.snap_seq, 5);

    // Mode toggle discards a partial block; sample in the change cycle starts the new one
    bus.mode_avg = 1'b1;
    strobe(50, -50, 50);
    strobe(50, -50, 50);
    bus.mode_avg = 1'b0;
    tick();
    bus.mode_avg = 1'b1;
    strobe(100, -100, 1);
    strobe(100, -100, 2);
    strobe(100, -100, 3);
    expect_res(100, -100, 2);
    strobe(100, -100, 4);
    tick();

    // Reset while holding with a half-full accumulator
    bus.snap_req = 1'b1;
    tick();
    strobe(30000, 20, -7);
    strobe(30000, 20, -7);
    strobe(30000, 20, -7);
    expect_res(30000, 20, -7);
    expect_snap(30000, 20, -7, 11);
    strobe(30000, 20, -7);
    tick();
    chk("hold2_ack", bus.snap_ack, 1);
    bus.led_sel = 2'd0;
    tick();
    chk("led_ch0", bus.led_bar, 10'h3FF);
    strobe(500, 500, 500);
    strobe(500, 500, 500);
    rst = 1'b1;
    tick();
    chk("rst2_ack", bus.snap_ack, 0);
    chk("rst2_led", bus.led_bar, 0);
    chk("rst2_seq", dut.r_seq, 0);
    chk("rst2_snap_seq", bus.snap_seq, 0);
    rst = 1'b0;
    bus.snap_req = 1'b0;
    exp_seq = '0;
    strobe(8, -5, 3);
    strobe(12, -5, 0);
    strobe(16, -5, 0);
    expect_res(14, -6, 0);
    strobe(20, -6, 0);
    tick();
    tick();
    chk("rq_drained", 64'(rq.size()), 0);
    chk("sq_drained", 64'(sq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
